// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
// Direction codes are common to direction_queue, FSM_direction and pixel_gen.
// Contents: DIR_W, the dir_e direction code enum and the opposite_of() helper.
package snake_pkg;

    localparam int DIR_W = 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // Reversal partner of a direction; NONE (and any unused code) maps to NONE.
    function automatic dir_e opposite_of(input dir_e dir);
        case (dir)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/direction_queue_if.sv
// Bus between the button front end / game timer and direction_queue.
// Inputs to the queue : one_up, one_down, one_left, one_right (press pulses),
//                       gaming (game running), tick (game-step strobe).
// Outputs of the queue: direction (applied code), opposite (reversal reject pulse),
//                       queue_count (buffered entries), overflow (sticky drop flag).
// master: the side driving presses/ticks; slave: the direction_queue itself.
interface direction_queue_if #(
    parameter int CNT_W = 3
);
    import snake_pkg::*;

    logic             one_up;
    logic             one_down;
    logic             one_left;
    logic             one_right;
    logic             gaming;
    logic             tick;
    logic [DIR_W-1:0] direction;
    logic             opposite;
    logic [CNT_W-1:0] queue_count;
    logic             overflow;

    modport master (
        output one_up, one_down, one_left, one_right, gaming, tick,
        input  direction, opposite, queue_count, overflow
    );

    modport slave (
        input  one_up, one_down, one_left, one_right, gaming, tick,
        output direction, opposite, queue_count, overflow
    );

endinterface

// File: rtl/direction_queue_dir_fifo.sv
// dir_fifo: DEPTH-entry circular buffer of direction codes.
// Ports: clk, rst (async, active-high); push/din enqueue, pop dequeue,
//        flush empties the buffer (wins over push/pop);
//        head = oldest entry, tail = newest entry, count = occupancy,
//        full/empty derived from count.
// A push while full is accepted only when a pop happens in the same cycle.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  dir_e             din,
    output dir_e             head,
    output dir_e             tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    dir_e             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~flush & ~empty;
    assign do_push  = push & ~flush & (~full | do_pop);
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];

    // Storage carries no reset; entries are only observed while count>0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/direction_queue.sv
// direction_queue: buffers one-pulsed direction presses and releases one per
// game-step tick, so quick double turns inside one step are kept in order.
// Ports: clk, rst (async, active-high); bus (direction_queue_if.slave):
//   presses one_up/one_down/one_left/one_right, gaming, tick in;
//   direction, opposite, queue_count, overflow out (all registered).
// Presses equal to the reference direction are ignored; reversals of it are
// rejected and reported on opposite. The reference is the newest queued entry,
// or the applied direction when the queue is empty.
module direction_queue
    import snake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic                   clk,
    input logic                   rst,
    direction_queue_if.slave      bus
);

    dir_e             direction_q;
    logic             opposite_q;
    logic             overflow_q;
    logic             gaming_q;

    dir_e             winner;
    dir_e             ref_dir;
    dir_e             fifo_head;
    dir_e             fifo_tail;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             game_start;
    logic             pop_req;
    logic             push_req;
    logic             is_reversal;
    logic             is_new;
    logic             drop;

    // Fixed-priority pick among simultaneous presses: UP > DOWN > LEFT > RIGHT.
    always_comb begin
        winner = DIR_NONE;
        if (bus.one_up) begin
            winner = DIR_UP;
        end else if (bus.one_down) begin
            winner = DIR_DOWN;
        end else if (bus.one_left) begin
            winner = DIR_LEFT;
        end else if (bus.one_right) begin
            winner = DIR_RIGHT;
        end
    end

    // Reference uses the pre-pop tail, so a same-cycle pop does not change it.
    assign ref_dir     = fifo_empty ? direction_q : fifo_tail;
    assign game_start  = bus.gaming & ~gaming_q;
    assign pop_req     = bus.gaming & bus.tick & ~fifo_empty;
    assign is_reversal = bus.gaming & (winner != DIR_NONE) & (winner == opposite_of(ref_dir));
    assign is_new      = bus.gaming & (winner != DIR_NONE) & (winner != ref_dir) & ~is_reversal;
    assign push_req    = is_new & (~fifo_full | pop_req);
    assign drop        = is_new & fifo_full & ~pop_req;

    dir_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dir_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_req),
        .flush (~bus.gaming),
        .din   (winner),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A game start always finds the queue flushed, so it never coincides with a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direction_q <= DIR_RIGHT;
            opposite_q  <= 1'b0;
            overflow_q  <= 1'b0;
            gaming_q    <= 1'b0;
        end else begin
            gaming_q   <= bus.gaming;
            opposite_q <= is_reversal;
            if (pop_req) begin
                direction_q <= fifo_head;
            end else if (game_start) begin
                direction_q <= DIR_RIGHT;
            end
            if (game_start) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.direction   = direction_q;
    assign bus.opposite    = opposite_q;
    assign bus.queue_count = fifo_count;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue: a queue-based reference model is
// stepped on every clock, compared against the DUT on every falling edge, and
// pinned by hand-computed expectations at each scenario checkpoint.
module tb_direction_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_on   = 0;

    direction_queue_if #(.CNT_W(CNT_W)) bus ();

    direction_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int q[$];
    int m_dir = 4;
    int m_opp = 0;
    int m_ovf = 0;
    int m_g   = 0;

    function automatic int rev(input int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_dir = 4;
        m_opp = 0;
        m_ovf = 0;
        m_g   = 0;
    endtask

    task automatic model_step();
        int  win;
        int  rf;
        int  new_dir;
        bit  pop;
        bit  push;
        if (!bus.gaming) begin
            q.delete();
            m_opp = 0;
        end else begin
            win = bus.one_up ? 1 : bus.one_down ? 2 : bus.one_left ? 3 : bus.one_right ? 4 : 0;
            rf  = (q.size() > 0) ? q[$] : m_dir;
            pop = bus.tick && (q.size() > 0);
            push = 0;
            new_dir = m_dir;
            if (m_g == 0) begin
                new_dir = 4;
                m_ovf   = 0;
            end
            if (pop) new_dir = q[0];
            m_opp = 0;
            if (win != 0 && win != rf) begin
                if (win == rev(rf)) m_opp = 1;
                else if (q.size() < DEPTH || pop) push = 1;
                else m_ovf = 1;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(win);
            m_dir = new_dir;
        end
        m_g = int'(bus.gaming);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("cmp_direction", int'(bus.direction), m_dir);
            check("cmp_opposite", int'(bus.opposite), m_opp);
            check("cmp_queue_count", int'(bus.queue_count), q.size());
            check("cmp_overflow", int'(bus.overflow), m_ovf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_presses();
        bus.one_up    = 1'b0;
        bus.one_down  = 1'b0;
        bus.one_left  = 1'b0;
        bus.one_right = 1'b0;
        bus.tick      = 1'b0;
    endtask

    task automatic press(input int d);
        case (d)
            1: bus.one_up    = 1'b1;
            2: bus.one_down  = 1'b1;
            3: bus.one_left  = 1'b1;
            default: bus.one_right = 1'b1;
        endcase
        step();
        clear_presses();
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        step();
        clear_presses();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.gaming = 1'b0;
        clear_presses();
        step();
        step();
        rst = 1'b0;
        cmp_on = 1;
        step();
        check("t1_reset_direction", int'(bus.direction), 4);
        check("t1_reset_count", int'(bus.queue_count), 0);
        check("t1_reset_overflow", int'(bus.overflow), 0);
        check("t1_reset_opposite", int'(bus.opposite), 0);
        bus.gaming = 1'b1;
        step();
        step();
        check("t1_start_direction", int'(bus.direction), 4);

        // Two buffered turns released one per tick.
        press(1);
        step();
        step();
        press(3);
        check("t2_count_two", int'(bus.queue_count), 2);
        tick_once();
        check("t2_first_pop_up", int'(bus.direction), 1);
        check("t2_count_one", int'(bus.queue_count), 1);
        tick_once();
        check("t2_second_pop_left", int'(bus.direction), 3);
        check("t2_count_zero", int'(bus.queue_count), 0);

        // New game to get back to RIGHT, then reversal and same-direction presses.
        bus.gaming = 1'b0;
        step();
        bus.gaming = 1'b1;
        step();
        check("t3_direction_right", int'(bus.direction), 4);
        press(3);
        check("t3_reversal_count", int'(bus.queue_count), 0);
        check("t3_opposite_pulse", int'(bus.opposite), 1);
        step();
        check("t3_opposite_cleared", int'(bus.opposite), 0);
        press(4);
        check("t3_same_count", int'(bus.queue_count), 0);
        check("t3_same_no_flag", int'(bus.opposite), 0);

        // Fill, overflow, then push+pop while full.
        press(1);
        press(3);
        press(2);
        press(4);
        check("t4_full_count", int'(bus.queue_count), 4);
        press(1);
        check("t4_drop_overflow", int'(bus.overflow), 1);
        check("t4_drop_count", int'(bus.queue_count), 4);
        check("t4_drop_direction", int'(bus.direction), 4);
        bus.one_up = 1'b1;
        bus.tick   = 1'b1;
        step();
        clear_presses();
        check("t4_pushpop_count", int'(bus.queue_count), 4);
        check("t4_pushpop_direction", int'(bus.direction), 1);
        check("t4_overflow_sticky", int'(bus.overflow), 1);

        // Flush holds direction; game start restores RIGHT and clears overflow.
        bus.gaming = 1'b0;
        step();
        check("t5_flush_count", int'(bus.queue_count), 0);
        check("t5_hold_direction", int'(bus.direction), 1);
        bus.gaming = 1'b1;
        step();
        check("t5_start_direction", int'(bus.direction), 4);
        check("t5_start_overflow", int'(bus.overflow), 0);
        bus.one_down = 1'b1;
        bus.one_left = 1'b1;
        step();
        clear_presses();
        check("t5_priority_count", int'(bus.queue_count), 1);
        bus.gaming = 1'b0;
        step();
        check("t5_off_count", int'(bus.queue_count), 0);
        check("t5_off_direction", int'(bus.direction), 4);
        bus.gaming = 1'b1;
        step();
        check("t5_on_direction", int'(bus.direction), 4);
        check("t5_on_overflow", int'(bus.overflow), 0);

        // Asynchronous reset between clock edges.
        press(1);
        press(3);
        check("t6_count_two", int'(bus.queue_count), 2);
        check("t6_direction_before", int'(bus.direction), 4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_count", int'(bus.queue_count), 0);
        check("t6_async_direction", int'(bus.direction), 4);
        check("t6_async_opposite", int'(bus.opposite), 0);
        check("t6_async_overflow", int'(bus.overflow), 0);
        #2;
        rst = 1'b0;
        step();
        step();
        check("t6_after_count", int'(bus.queue_count), 0);

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
